// File: rtl/crc8_serial_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc8_serial_engine_pkg
//  Description : Shared definitions for the bit-serial CRC engine: FSM state
//                encodings, CRC-8/SMBUS default parameters and the saturating
//                bit counter helper.
//  Contents    : state_t (ST_IDLE / ST_RUN / ST_DONE, 2-bit encoding)
//                CRC8_POLY, CRC8_INIT, CRC8_XOR_OUT, CNT_MAX
//                sat_inc() - 16-bit increment that sticks at CNT_MAX
//  Revision    : 1.0 - initial release
// ============================================================================
package crc8_serial_engine_pkg;

   // Engine states. The encoding is fixed so that the state can be observed
   // and compared against other implementations of the same engine.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // CRC-8/SMBUS: x^8 + x^2 + x + 1, zero init, no output inversion.
   localparam logic [7:0]  CRC8_POLY    = 8'h07;
   localparam logic [7:0]  CRC8_INIT    = 8'h00;
   localparam logic [7:0]  CRC8_XOR_OUT = 8'h00;

   localparam logic [15:0] CNT_MAX      = 16'hFFFF;

   // Increment that holds at the all-ones value instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == CNT_MAX) ? v : v + 16'd1;
   endfunction

endpackage : crc8_serial_engine_pkg
`default_nettype wire

// File: rtl/crc8_serial_engine_crc_step.sv
`default_nettype none
// ============================================================================
//  Module      : crc8_serial_engine_crc_step
//  Description : Combinational single-bit CRC update, MSB-first.
//                   fb    = crc[WIDTH-1] ^ bit
//                   next  = {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : 0)
//                Built from xor gate primitives so that gate-level netlists
//                keep the same unit-delay structure as the upstream XOR stage.
//  Ports       : crc_i  [WIDTH-1:0] in  current CRC register value
//                bit_i              in  incoming data bit
//                crc_o  [WIDTH-1:0] out CRC value after folding in bit_i
//  Revision    : 1.0 - initial release
// ============================================================================
module crc8_serial_engine_crc_step
   import crc8_serial_engine_pkg::*;
#(
   parameter int                 WIDTH = 8,
   parameter logic [WIDTH-1:0]   POLY  = WIDTH'(CRC8_POLY)
) (
   input  logic [WIDTH-1:0] crc_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] crc_o
);

   wire             w_fb;
   wire [WIDTH-1:0] w_next;

   // Feedback: the bit shifted out of the register combined with the data.
   xor u_fb (w_fb, crc_i[WIDTH-1], bit_i);

   // POLY is a constant, so each tap collapses either to an xor with the
   // feedback or to a plain wire from the neighbouring register bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lsb
         if (POLY[0]) begin : g_tap
            assign w_next[0] = w_fb;
         end else begin : g_notap
            assign w_next[0] = 1'b0;
         end
      end else begin : g_upper
         if (POLY[i]) begin : g_tap
            xor u_tap (w_next[i], crc_i[i-1], w_fb);
         end else begin : g_notap
            assign w_next[i] = crc_i[i-1];
         end
      end
   end

   assign crc_o = w_next;

endmodule : crc8_serial_engine_crc_step
`default_nettype wire

// File: rtl/crc8_serial_engine.sv
`default_nettype none
// ============================================================================
//  Module      : crc8_serial_engine
//  Description : Bit-serial CRC accumulator. Consumes one data bit per clock
//                from the XOR stage, frames the stream with start/bit_last,
//                reports the final CRC with a one-cycle valid pulse and
//                compares it against an expected value.
//  Ports       : clk                 in  rising-edge clock
//                rst_n               in  asynchronous active-low reset
//                start               in  begin (or restart) a frame
//                bit_in              in  data bit, MSB-first
//                bit_valid           in  bit_in valid this cycle
//                bit_last            in  final bit of frame (with bit_valid)
//                bit_ready           out engine accepts a bit this cycle
//                crc_exp [WIDTH-1:0] in  expected CRC, sampled on last bit
//                crc_out [WIDTH-1:0] out final CRC after XOR_OUT
//                crc_valid           out one-cycle pulse, crc_out/crc_ok valid
//                crc_ok              out crc_out == crc_exp
//                busy                out engine is in the RUN state
//                bit_count [15:0]    out bits accepted, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module crc8_serial_engine
   import crc8_serial_engine_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] POLY    = WIDTH'(CRC8_POLY),
   parameter logic [WIDTH-1:0] INIT    = WIDTH'(CRC8_INIT),
   parameter logic [WIDTH-1:0] XOR_OUT = WIDTH'(CRC8_XOR_OUT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             bit_last,
   output logic             bit_ready,
   input  logic [WIDTH-1:0] crc_exp,
   output logic [WIDTH-1:0] crc_out,
   output logic             crc_valid,
   output logic             crc_ok,
   output logic             busy,
   output logic [15:0]      bit_count
);

   state_t             state_q;
   logic [WIDTH-1:0]   crc_q;
   logic [WIDTH-1:0]   crc_d;
   logic [WIDTH-1:0]   final_d;
   logic [WIDTH-1:0]   crc_out_q;
   logic               crc_valid_q;
   logic               crc_ok_q;
   logic               bit_ready_q;
   logic               busy_q;
   logic [15:0]        bit_count_q;
   logic [15:0]        bit_count_d;
   logic               accept;

   // ------------------------------------------------------------------
   // Datapath: one CRC step per accepted bit
   // ------------------------------------------------------------------
   crc8_serial_engine_crc_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_step (
      .crc_i (crc_q),
      .bit_i (bit_in),
      .crc_o (crc_d)
   );

   assign final_d     = crc_d ^ XOR_OUT;
   assign bit_count_d = sat_inc(bit_count_q);

   // bit_ready_q is high exactly in RUN, so this is the handshake.
   assign accept      = bit_ready_q & bit_valid;

   // ------------------------------------------------------------------
   // FSM with registered outputs. bit_ready/busy are loaded together with
   // the state so they are pure flop outputs, never a path from inputs.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         crc_q       <= INIT;
         crc_out_q   <= '0;
         crc_valid_q <= 1'b0;
         crc_ok_q    <= 1'b0;
         bit_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         bit_count_q <= '0;
      end else begin
         // Pulse output: only the RUN->DONE transition raises it.
         crc_valid_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q     <= ST_RUN;
                  crc_q       <= INIT;
                  bit_count_q <= '0;
                  bit_ready_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end

            ST_RUN: begin
               if (start) begin
                  // Restart wins over any bit offered in the same cycle,
                  // including one flagged as last.
                  crc_q       <= INIT;
                  bit_count_q <= '0;
               end else if (accept) begin
                  crc_q       <= crc_d;
                  bit_count_q <= bit_count_d;
                  if (bit_last) begin
                     crc_out_q   <= final_d;
                     crc_ok_q    <= (final_d == crc_exp);
                     crc_valid_q <= 1'b1;
                     state_q     <= ST_DONE;
                     bit_ready_q <= 1'b0;
                     busy_q      <= 1'b0;
                  end
               end
            end

            ST_DONE: begin
               // Holding start here gives a 2-cycle last-to-first-bit
               // turnaround between frames.
               if (start) begin
                  state_q     <= ST_RUN;
                  crc_q       <= INIT;
                  bit_count_q <= '0;
                  bit_ready_q <= 1'b1;
                  busy_q      <= 1'b1;
               end else begin
                  state_q     <= ST_IDLE;
               end
            end

            default: begin
               state_q     <= ST_IDLE;
               bit_ready_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bit_ready = bit_ready_q;
   assign busy      = busy_q;
   assign crc_out   = crc_out_q;
   assign crc_valid = crc_valid_q;
   assign crc_ok    = crc_ok_q;
   assign bit_count = bit_count_q;

endmodule : crc8_serial_engine
`default_nettype wire

// File: tb/tb_crc8_serial_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc8_serial_engine
//  Description : Scoreboard bench for crc8_serial_engine. Stimulus pushes the
//                hand-computed frame result into a queue; a monitor pops and
//                compares it whenever crc_valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc8_serial_engine;

   typedef struct packed {
      logic [7:0]  crc;
      logic        ok;
      logic [15:0] cnt;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        bit_in;
   logic        bit_valid;
   logic        bit_last;
   logic        bit_ready;
   logic [7:0]  crc_exp;
   logic [7:0]  crc_out;
   logic        crc_valid;
   logic        crc_ok;
   logic        busy;
   logic [15:0] bit_count;

   int          n_cmp;
   int          n_err;
   int          cyc_cnt;
   int          valid_cycles[$];
   exp_t        exp_q[$];
   logic        prev_valid;

   crc8_serial_engine dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .bit_last  (bit_last),
      .bit_ready (bit_ready),
      .crc_exp   (crc_exp),
      .crc_out   (crc_out),
      .crc_valid (crc_valid),
      .crc_ok    (crc_ok),
      .busy      (busy),
      .bit_count (bit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] c, input logic o, input logic [15:0] n);
      exp_t e;
      e.crc = c;
      e.ok  = o;
      e.cnt = n;
      return e;
   endfunction

   // Inputs change 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         bit_in    = b[i];
         bit_valid = 1'b1;
         bit_last  = (i == 0);
         cyc();
      end
      bit_valid = 1'b0;
      bit_last  = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_crc_out"},   32'(crc_out),   32'h0);
      chk({tag, "_crc_valid"}, 32'(crc_valid), 32'h0);
      chk({tag, "_crc_ok"},    32'(crc_ok),    32'h0);
      chk({tag, "_bit_ready"}, 32'(bit_ready), 32'h0);
      chk({tag, "_busy"},      32'(busy),      32'h0);
      chk({tag, "_bit_count"}, 32'(bit_count), 32'h0);
   endtask

   // ------------------------------------------------------------------
   // Monitor: compare each crc_valid pulse against the scoreboard head.
   // ------------------------------------------------------------------
   initial begin : monitor
      exp_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (crc_valid === 1'b1) begin
            valid_cycles.push_back(cyc_cnt);
            chk("valid_one_cycle", 32'(prev_valid), 32'h0);
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 32'(crc_valid), 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk("crc_out",   32'(crc_out),   32'(e.crc));
               chk("crc_ok",    32'(crc_ok),    32'(e.ok));
               chk("bit_count", 32'(bit_count), 32'(e.cnt));
            end
         end
         prev_valid = crc_valid;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1);
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin : stim
      logic [7:0] msg [9];
      int         n;
      int         idx;
      logic [4:0] pre;

      msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      pre = 5'b11010;
      n_cmp = 0;
      n_err = 0;

      rst_n     = 1'b0;
      start     = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      bit_last  = 1'b0;
      crc_exp   = 8'h00;
      #3;
      chk_reset_vals("por");
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();

      // Idle: bits are ignored, bit_last alone does nothing.
      bit_valid = 1'b1;
      bit_last  = 1'b1;
      cyc();
      bit_valid = 1'b0;
      bit_last  = 1'b0;
      chk("idle_ready", 32'(bit_ready), 32'h0);
      chk("idle_busy",  32'(busy),      32'h0);

      // Byte 0x01 -> 0x07.
      crc_exp = 8'h07;
      exp_q.push_back(mk(8'h07, 1'b1, 16'd8));
      start_frame();
      chk("run_busy",  32'(busy),      32'h1);
      chk("run_ready", 32'(bit_ready), 32'h1);
      send_byte(8'h01);
      repeat (3) cyc();

      // Byte 0x80 -> 0x89, matching and non-matching expectation.
      crc_exp = 8'h89;
      exp_q.push_back(mk(8'h89, 1'b1, 16'd8));
      start_frame();
      send_byte(8'h80);
      repeat (2) cyc();
      crc_exp = 8'h00;
      exp_q.push_back(mk(8'h89, 1'b0, 16'd8));
      start_frame();
      send_byte(8'h80);
      repeat (2) cyc();

      // "123456789" with valid gaps (bit_last high in gaps) -> 0xF4.
      crc_exp = 8'hF4;
      exp_q.push_back(mk(8'hF4, 1'b1, 16'd72));
      start_frame();
      n = 0;
      for (int k = 0; k < 9; k++) begin
         for (int i = 7; i >= 0; i--) begin
            if ((n % 3) == 2) begin
               bit_valid = 1'b0;
               bit_last  = 1'b1;
               cyc();
            end
            bit_in    = msg[k][i];
            bit_valid = 1'b1;
            bit_last  = (k == 8) && (i == 0);
            cyc();
            n++;
         end
      end
      bit_valid = 1'b0;
      bit_last  = 1'b0;
      repeat (3) cyc();

      // Restart after 5 bits; the bit offered with start is dropped.
      crc_exp = 8'h07;
      exp_q.push_back(mk(8'h07, 1'b1, 16'd8));
      start_frame();
      for (int i = 4; i >= 0; i--) begin
         bit_in    = pre[i];
         bit_valid = 1'b1;
         bit_last  = 1'b0;
         cyc();
      end
      start     = 1'b1;
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      bit_last  = 1'b1;
      cyc();
      start     = 1'b0;
      bit_valid = 1'b0;
      bit_last  = 1'b0;
      chk("restart_busy",  32'(busy),      32'h1);
      chk("restart_count", 32'(bit_count), 32'h0);
      send_byte(8'h01);
      repeat (3) cyc();

      // Back-to-back frames with start held during DONE.
      idx = valid_cycles.size();
      crc_exp = 8'h07;
      exp_q.push_back(mk(8'h07, 1'b1, 16'd8));
      exp_q.push_back(mk(8'h89, 1'b0, 16'd8));
      start_frame();
      send_byte(8'h01);
      start = 1'b1;
      cyc();
      start = 1'b0;
      send_byte(8'h80);
      repeat (4) cyc();
      chk("b2b_pulses", 32'(valid_cycles.size() - idx), 32'd2);
      if (valid_cycles.size() >= idx + 2)
         chk("b2b_gap", 32'(valid_cycles[idx+1] - valid_cycles[idx]), 32'd9);
      chk("hold_crc_out",   32'(crc_out),   32'h89);
      chk("hold_bit_count", 32'(bit_count), 32'd8);

      // Reset mid-frame: outputs clear immediately, no valid afterwards.
      idx = valid_cycles.size();
      start_frame();
      for (int i = 0; i < 4; i++) begin
         bit_in    = i[0];
         bit_valid = 1'b1;
         bit_last  = 1'b0;
         cyc();
      end
      bit_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      cyc();
      rst_n = 1'b1;
      bit_valid = 1'b1;
      bit_last  = 1'b1;
      repeat (3) cyc();
      bit_valid = 1'b0;
      bit_last  = 1'b0;
      repeat (5) cyc();
      chk("no_valid_after_reset", 32'(valid_cycles.size() - idx), 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_crc8_serial_engine
`default_nettype wire
